// File: rtl/active_device_monitor_n_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | active_device_monitor_n_if : event lanes in, count/flags/alarm out          |
// | Optional peak_out when ACTIVE_MON_PEAK_EN is defined.   Rev 1.0             |
// +----------------------------------------------------------------------------+
interface active_device_monitor_n_if #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
);
    logic [N_CH-1:0]  change;
    logic [N_CH-1:0]  on_off;
    logic             clr_flags;
    logic [WIDTH-1:0] counter_out;
    logic             ovf;
    logic             udf;
    logic             alarm;
`ifdef ACTIVE_MON_PEAK_EN
    logic [WIDTH-1:0] peak_out;

    modport master (output change, on_off, clr_flags,
                    input  counter_out, ovf, udf, alarm, peak_out);
    modport slave  (input  change, on_off, clr_flags,
                    output counter_out, ovf, udf, alarm, peak_out);
`else
    modport master (output change, on_off, clr_flags,
                    input  counter_out, ovf, udf, alarm);
    modport slave  (input  change, on_off, clr_flags,
                    output counter_out, ovf, udf, alarm);
`endif
endinterface
`default_nettype wire

// File: rtl/active_device_monitor_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | active_device_monitor_n : N-lane active device counter, sticky ovf/udf,    |
// | hysteresis alarm; peak_out high-water mark under ACTIVE_MON_PEAK_EN. Rev 1.0|
// +----------------------------------------------------------------------------+
module active_device_monitor_n #(
    parameter int WIDTH     = 8,
    parameter int N_CH      = 4,
    parameter int SATURATE  = 1,
    parameter int HI_THRESH = 10,
    parameter int LO_THRESH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    active_device_monitor_n_if.slave    bus
);
    localparam int CNT_W = $clog2(N_CH + 1);
    localparam int SUM_W = WIDTH + $clog2(N_CH) + 2;
    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_HI  = WIDTH'(HI_THRESH);
    localparam logic [WIDTH-1:0] C_LO  = WIDTH'(LO_THRESH);

    logic [WIDTH-1:0]        count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    udf_q, udf_d;
    logic                    alarm_q, alarm_d;
    logic [CNT_W-1:0]        w_up, w_dn;
    logic signed [SUM_W-1:0] w_sum;
    logic                    w_neg, w_over;

    always_comb begin
        w_up = '0;
        w_dn = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_up = w_up + CNT_W'(bus.change[i] &  bus.on_off[i]);
            w_dn = w_dn + CNT_W'(bus.change[i] & ~bus.on_off[i]);
        end
        w_sum  = SUM_W'(count_q) + SUM_W'(w_up) - SUM_W'(w_dn);
        w_neg  = w_sum[SUM_W-1];
        // Headroom bits above WIDTH set on a non-negative sum mean it exceeded MAX.
        w_over = ~w_neg & (|w_sum[SUM_W-2:WIDTH]);
    end

    generate
        if (SATURATE != 0) begin : g_sat
            always_comb begin
                count_d = w_sum[WIDTH-1:0];
                if (w_over)
                    count_d = C_MAX;
                else if (w_neg)
                    count_d = '0;
            end
        end else begin : g_wrap
            assign count_d = w_sum[WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        alarm_d = alarm_q;
        if (count_d >= C_HI)
            alarm_d = 1'b1;
        else if (count_d <= C_LO)
            alarm_d = 1'b0;
        // A fresh overflow/underflow beats a simultaneous clear.
        ovf_d = w_over | (ovf_q & ~bus.clr_flags);
        udf_d = w_neg  | (udf_q & ~bus.clr_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            alarm_q <= alarm_d;
        end
    end

`ifdef ACTIVE_MON_PEAK_EN
    logic [WIDTH-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (bus.clr_flags)
            peak_d = count_d;
        else if (count_d > peak_q)
            peak_d = count_d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            peak_q <= '0;
        else
            peak_q <= peak_d;
    end

    assign bus.peak_out = peak_q;
`endif

    assign bus.counter_out = count_q;
    assign bus.ovf         = ovf_q;
    assign bus.udf         = udf_q;
    assign bus.alarm       = alarm_q;
endmodule
`default_nettype wire

// File: tb/tb_active_device_monitor_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_active_device_monitor_n : scoreboard bench, saturate and wrap DUTs      |
// | driven in lockstep; peak_out checked when ACTIVE_MON_PEAK_EN.   Rev 1.0     |
// +----------------------------------------------------------------------------+
module tb_active_device_monitor_n;
    typedef struct {
        int cnt;
        int ovf;
        int udf;
        int alm;
        int pk;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t q_exp[2][$];
    exp_t m[2];

    active_device_monitor_n_if #(.WIDTH(8), .N_CH(4)) if_sat ();
    active_device_monitor_n_if #(.WIDTH(8), .N_CH(4)) if_wrp ();

    active_device_monitor_n #(.WIDTH(8), .N_CH(4), .SATURATE(1), .HI_THRESH(10), .LO_THRESH(5))
        u_sat (.clk(clk), .rst(rst), .bus(if_sat.slave));
    active_device_monitor_n #(.WIDTH(8), .N_CH(4), .SATURATE(0), .HI_THRESH(10), .LO_THRESH(5))
        u_wrp (.clk(clk), .rst(rst), .bus(if_wrp.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent reference: integer arithmetic on the whole sum, then clamp or wrap.
    task automatic model(input int j, input logic [3:0] ch, input logic [3:0] oo,
                         input logic clr, input logic r);
        int up, dn, sum, nxt;
        up = 0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (ch[i] && oo[i])  up++;
            if (ch[i] && !oo[i]) dn++;
        end
        sum = m[j].cnt + up - dn;
        if (j == 0) nxt = (sum > 255) ? 255 : (sum < 0) ? 0 : sum;
        else        nxt = (sum + 256) % 256;
        if (r) begin
            m[j] = '{0, 0, 0, 0, 0};
        end else begin
            m[j].ovf = (sum > 255) ? 1 : (clr ? 0 : m[j].ovf);
            m[j].udf = (sum < 0)   ? 1 : (clr ? 0 : m[j].udf);
            if (nxt >= 10)     m[j].alm = 1;
            else if (nxt <= 5) m[j].alm = 0;
            if (clr)                m[j].pk = nxt;
            else if (nxt > m[j].pk) m[j].pk = nxt;
            m[j].cnt = nxt;
        end
        q_exp[j].push_back(m[j]);
    endtask

    task automatic check_dut(input int j);
        exp_t e;
        logic [7:0] cnt, pk;
        logic ov, ud, al;
        string nm;
        nm = (j == 0) ? "sat" : "wrp";
        if (q_exp[j].size() == 0) begin
            chk({nm, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = q_exp[j].pop_front();
        if (j == 0) begin
            cnt = if_sat.counter_out; ov = if_sat.ovf; ud = if_sat.udf; al = if_sat.alarm;
`ifdef ACTIVE_MON_PEAK_EN
            pk = if_sat.peak_out;
`else
            pk = 8'd0;
`endif
        end else begin
            cnt = if_wrp.counter_out; ov = if_wrp.ovf; ud = if_wrp.udf; al = if_wrp.alarm;
`ifdef ACTIVE_MON_PEAK_EN
            pk = if_wrp.peak_out;
`else
            pk = 8'd0;
`endif
        end
        chk({nm, ".count"}, 32'(cnt), 32'(e.cnt));
        chk({nm, ".ovf"},   32'(ov),  32'(e.ovf));
        chk({nm, ".udf"},   32'(ud),  32'(e.udf));
        chk({nm, ".alarm"}, 32'(al),  32'(e.alm));
`ifdef ACTIVE_MON_PEAK_EN
        chk({nm, ".peak"},  32'(pk),  32'(e.pk));
`endif
    endtask

    task automatic step(input logic [3:0] ch, input logic [3:0] oo,
                        input logic clr = 1'b0, input logic r = 1'b0);
        rst              = r;
        if_sat.change    = ch;  if_sat.on_off = oo;  if_sat.clr_flags = clr;
        if_wrp.change    = ch;  if_wrp.on_off = oo;  if_wrp.clr_flags = clr;
        model(0, ch, oo, clr, r);
        model(1, ch, oo, clr, r);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
    endtask

    initial begin
        int guard;
        n_vec = 0;
        n_err = 0;
        m[0]  = '{0, 0, 0, 0, 0};
        m[1]  = '{0, 0, 0, 0, 0};
        rst   = 1'b1;
        if_sat.change = '0; if_sat.on_off = '0; if_sat.clr_flags = 1'b0;
        if_wrp.change = '0; if_wrp.on_off = '0; if_wrp.clr_flags = 1'b0;
        @(negedge clk);

        // Reset dominates a full burst of joins.
        repeat (10) step(4'hF, 4'hF, 1'b0, 1'b1);
        repeat (10) step(4'h0, 4'h0);

        // Single lane up through the high threshold, then down to the low one.
        repeat (12) step(4'b0001, 4'b0001);
        repeat (7)  step(4'b0001, 4'b0000);

        // Balanced lanes net to zero, then a full up burst.
        repeat (5) step(4'hF, 4'b0011);
        repeat (3) step(4'hF, 4'hF);

        // Climb to 254 so the wrap DUT overflows by exactly 3.
        guard = 0;
        while (m[0].cnt <= 250 && guard < 100) begin step(4'hF, 4'hF); guard++; end
        while (m[0].cnt < 254 && guard < 200) begin step(4'b0001, 4'b0001); guard++; end
        chk("climb_to_254", 32'(m[0].cnt), 32'd254);
        step(4'b0111, 4'hF);
        step(4'b0011, 4'h0);
        step(4'h0, 4'h0, 1'b1);

        // Saturating overflow, clear, descend to 2, underflow, clear collides with new udf.
        step(4'hF, 4'hF);
        step(4'h0, 4'h0, 1'b1);
        guard = 0;
        while (m[0].cnt > 5 && guard < 100) begin step(4'hF, 4'h0); guard++; end
        while (m[0].cnt > 2 && guard < 200) begin step(4'b0100, 4'h0); guard++; end
        step(4'hF, 4'h0);
        step(4'hF, 4'h0, 1'b1);
        step(4'h0, 4'h0);

        // Random traffic with occasional flag clears.
        for (int k = 0; k < 200; k++)
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));

        // High-water mark sequence with a mid-burst reset.
        step(4'hF, 4'hF, 1'b0, 1'b1);
        repeat (5) step(4'hF, 4'hF);
        repeat (3) step(4'hF, 4'h0);
        step(4'h0, 4'h0, 1'b1);
        repeat (2) step(4'b0011, 4'hF);
        step(4'hF, 4'hF, 1'b1, 1'b1);
        step(4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/active_device_monitor_n.md
Name: active_device_monitor_n

Overview:
- Parametrised successor to the single-channel active IoT device counter.
- Accepts N_CH independent device event lanes. Each lane carries a change strobe and an on_off direction.
- Maintains a registered count of active devices, with selectable saturate or wrap arithmetic, sticky overflow/underflow flags and a hysteresis occupancy alarm.
- Sits between the device event aggregator and the status/reporting logic.

Parameters:
- WIDTH, 8: counter_out width; MAX_COUNT = 2^WIDTH-1.
- N_CH, 4: number of event lanes (1..16).
- SATURATE, 1: 1 = clamp count to [0, MAX_COUNT]; 0 = wrap modulo 2^WIDTH.
- HI_THRESH, 10: alarm asserts when the next count is >= HI_THRESH.
- LO_THRESH, 5: alarm deasserts when the next count is <= LO_THRESH. Must be < HI_THRESH.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- change, input, N_CH: per-lane event strobe; bit i valid for one cycle.
- on_off, input, N_CH: per-lane direction, sampled with change[i]; 1 = device joined, 0 = device left.
- clr_flags, input, 1: clears the sticky ovf/udf flags.
- counter_out, output, WIDTH: registered active-device count.
- ovf, output, 1: sticky flag; an increment exceeded MAX_COUNT.
- udf, output, 1: sticky flag; a decrement went below 0.
- alarm, output, 1: registered hysteresis occupancy alarm.

Behaviour:
- Reset:
  - One clock is used; reset is synchronous and active-high.
  - While rst=1 at a rising edge: counter_out=0, ovf=0, udf=0, alarm=0.
  - rst overrides all other inputs in the same cycle, including mid-burst events and clr_flags.
- Per-cycle arithmetic:
  - up = popcount(change & on_off); dn = popcount(change & ~on_off).
  - Compute sum = counter_out + up - dn in a signed intermediate of WIDTH+$clog2(N_CH)+2 bits. No truncation before the clamp/wrap step.
  - Lanes with change[i]=0 contribute nothing; on_off[i] is ignored for those lanes.
  - Simultaneous up and down events on different lanes net out in the same cycle. Example: 2 up + 2 down leaves the count unchanged and flags no ovf/udf.
- Next-count rule:
  - SATURATE=1: sum>MAX_COUNT → MAX_COUNT; sum<0 → 0; otherwise sum.
  - SATURATE=0: next count = sum mod 2^WIDTH.
  - Example: 255+1 → 0; 0-1 → 255.
- Latency: counter_out reflects events sampled at edge k immediately after edge k, i.e. 1-cycle latency. There is no combinational path from inputs to outputs.
- Flags:
  - ovf sets on any cycle where sum>MAX_COUNT.
  - udf sets on any cycle where sum<0.
  - Both flags set the same way in either SATURATE mode.
  - Flags hold until clr_flags=1 or rst=1.
  - If clr_flags coincides with a new ovf/udf condition, the set wins and the flag reads 1.
- Alarm:
  - alarm is evaluated on the next count, so it changes on the same edge as counter_out.
  - Next count >= HI_THRESH → alarm=1.
  - Next count <= LO_THRESH → alarm=0.
  - Strictly between the thresholds → alarm holds its value.
  - In wrap mode the alarm uses the wrapped value.
- No-event cycles (change=0): all state holds.

Optional Feature:
- Macro: ACTIVE_MON_PEAK_EN.
- When defined:
  - Adds output peak_out [WIDTH-1:0], a registered high-water mark of counter_out.
  - peak_out updates on the same edge as counter_out whenever the next count > peak_out.
  - Reset value 0; cleared to the current next count when clr_flags=1. The clear applies in the same cycle, so after clear peak_out = counter_out.
  - Never decreases otherwise.
- When undefined: the port and the register are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8, N_CH=4, HI=10, LO=5 unless noted.
1. Reset: hold rst=1 for 10 cycles with change=4'hF, on_off=4'hF → counter_out=0, ovf=udf=alarm=0 throughout. Release rst with change=0 for 10 cycles → counter_out stays 0.
2. Single lane: change=4'b0001, on_off=1 for 12 cycles → counter_out 1..12, each value one cycle after its event; alarm rises on the edge where the count becomes 10. Then on_off=0 for 7 cycles → count 5, alarm falls on reaching 5 and stays 0 below.
3. Simultaneous: change=4'hF, on_off=4'b0011 for 5 cycles → count unchanged. Then on_off=4'hF for 3 cycles → count +12.
4. Saturate (SATURATE=1): count 253, change=4'hF up → 255, ovf=1. Pulse clr_flags → ovf=0. From 2, apply 4 down events → 0, udf=1. Apply clr_flags in the same cycle as a new underflow → udf stays 1.
5. Wrap (SATURATE=0): 254 + 3 up → 1, ovf=1. Then 1 - 2 → 255, udf=1, alarm=1.
6. Peak (ACTIVE_MON_PEAK_EN defined): count up to 20, down to 8 → peak_out=20. Pulse clr_flags → peak_out=8. Assert rst mid-sequence → all outputs 0 on the next edge.
